rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port (RegWrite/WriteReg/WriteData) among NUM_REQ

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback requester indices.
// No logic; constants only.
// Imported by the write arbiter and its round-robin sub-block.
package rf_pkg;

   localparam int RF_ADDR_W   = 4;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

   // Writeback source slots on the arbiter request vector
   localparam int REQ_ALU  = 0;
   localparam int REQ_LD   = 1;
   localparam int REQ_LINK = 2;

   // Index width for a requester count, never below one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: searches from ptr+1 upward with wrap, returns one-hot grant and its index.
// Latency: purely combinational, no state.
// Backpressure: requesters not picked simply see gnt low and keep holding their request.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   // Scan priority order starting just after the last winner; first requester found wins
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single RF write port among NUM_REQ writeback sources and tracks writes in flight.
// Latency: accept at edge E, RegWrite/WriteReg/WriteData valid the cycle after E (RF commits at E+1).
// Backpressure: a requester holds req/addr/data until its gnt pulse; one accept per cycle, round-robin.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      RegWrite,
   output logic [ADDR_W-1:0]         WriteReg,
   output logic [DATA_W-1:0]         WriteData,
   input  logic                      reserve_en,
   input  logic [ADDR_W-1:0]         reserve_addr,
   input  logic [ADDR_W-1:0]         rd_addr1,
   input  logic [ADDR_W-1:0]         rd_addr2,
   output logic                      hazard1,
   output logic                      hazard2,
   output logic                      sb_err
);

   localparam int IDX_W    = idx_width(NUM_REQ);
   localparam int NUM_REGS = 1 << ADDR_W;

   logic [IDX_W-1:0]    ptr;
   logic [NUM_REQ-1:0]  arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;
   logic                accept;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_next;
   logic                clear_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (req),
      .ptr     (ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   // Grants are suppressed while reset is held so nothing is accepted into a dropped pipeline
   always_comb begin
      gnt    = rst ? '0 : arb_gnt;
      accept = arb_any & ~rst;
   end

   // Write-port registers and priority pointer; address/data hold when nothing is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         ptr       <= IDX_W'(NUM_REQ - 1);
      end else begin
         RegWrite <= accept;
         if (accept) begin
            WriteReg  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
            WriteData <= req_data[arb_idx*DATA_W +: DATA_W];
            ptr       <= arb_idx;
         end
      end
   end

   // Next scoreboard: commit clears first, then a same-edge reserve re-sets the bit
   always_comb begin
      pending_next = pending;
      if (RegWrite) begin
         pending_next[WriteReg] = 1'b0;
      end
      if (reserve_en) begin
         pending_next[reserve_addr] = 1'b1;
      end
      clear_hit = RegWrite && (WriteReg == reserve_addr);
   end

   // Scoreboard state and sticky double-reserve flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         sb_err  <= 1'b0;
      end else begin
         pending <= pending_next;
         if (reserve_en && pending[reserve_addr] && !clear_hit) begin
            sb_err <= 1'b1;
         end
      end
   end

   // Decode hazards read the live bits; still set during the commit cycle since the RF is stale
   always_comb begin
      hazard1 = pending[rd_addr1];
      hazard2 = pending[rd_addr2];
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small register-file model behind the write port.
// Inputs change and outputs are sampled around the falling edge.
// Each comparison goes through check(); a summary line closes the run.
module tb_rf_write_arbiter;

   localparam int NR = 3;
   localparam int AW = 4;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   req;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   gnt;
   logic            RegWrite;
   logic [AW-1:0]   WriteReg;
   logic [DW-1:0]   WriteData;
   logic            reserve_en;
   logic [AW-1:0]   reserve_addr;
   logic [AW-1:0]   rd_addr1;
   logic [AW-1:0]   rd_addr2;
   logic            hazard1;
   logic            hazard2;
   logic            sb_err;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rf [16];

   rf_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .gnt          (gnt),
      .RegWrite     (RegWrite),
      .WriteReg     (WriteReg),
      .WriteData    (WriteData),
      .reserve_en   (reserve_en),
      .reserve_addr (reserve_addr),
      .rd_addr1     (rd_addr1),
      .rd_addr2     (rd_addr2),
      .hazard1      (hazard1),
      .hazard2      (hazard2),
      .sb_err       (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: commits on the edge after a write is presented
   initial begin
      for (int i = 0; i < 16; i++) rf[i] = '0;
   end
   always @(posedge clk) begin
      if (RegWrite) rf[WriteReg] <= WriteData;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      rst          = 1'b1;
      req          = '0;
      req_addr     = '0;
      req_data     = '0;
      reserve_en   = 1'b0;
      reserve_addr = '0;
      rd_addr1     = '0;
      rd_addr2     = '0;
      step();
      step();
      check("rst_regwrite", RegWrite, 0);
      check("rst_gnt", gnt, 0);
      check("rst_sb_err", sb_err, 0);
      rst = 1'b0;
      step();

      // ---- Test 1: reset mid-write with pending = 0x00F0 ----
      for (int r = 4; r < 8; r++) begin
         reserve_en   = 1'b1;
         reserve_addr = AW'(r);
         step();
      end
      reserve_en = 1'b0;
      rd_addr1   = 4'd4;
      rd_addr2   = 4'd7;
      req        = 3'b001;
      set_req(0, 4'd9, 32'h1234_5678);
      #1;
      check("t1_haz1_pre", hazard1, 1);
      check("t1_haz2_pre", hazard2, 1);
      check("t1_gnt_pre", gnt, 3'b001);
      step();
      check("t1_regwrite_pre", RegWrite, 1);
      req = 3'b111;
      rst = 1'b1;
      #1;
      check("t1_regwrite", RegWrite, 0);
      check("t1_writereg", WriteReg, 0);
      check("t1_writedata", WriteData, 0);
      check("t1_haz1", hazard1, 0);
      check("t1_haz2", hazard2, 0);
      check("t1_gnt", gnt, 0);
      step();
      check("t1_gnt_held", gnt, 0);
      check("t1_dropped", rf[9], 0);
      req = '0;
      rst = 1'b0;
      step();

      // ---- Test 2: single request, ptr=2 so requester 0 wins ----
      req = 3'b001;
      set_req(0, 4'd3, 32'hDEAD_BEEF);
      #1;
      check("t2_gnt", gnt, 3'b001);
      step();
      req = '0;
      check("t2_regwrite", RegWrite, 1);
      check("t2_writereg", WriteReg, 3);
      check("t2_writedata", WriteData, 32'hDEAD_BEEF);
      step();
      check("t2_regwrite_off", RegWrite, 0);
      check("t2_writereg_hold", WriteReg, 3);
      check("t2_rf", rf[3], 32'hDEAD_BEEF);

      // ---- Test 3: round robin; first park ptr on requester 2 ----
      req = 3'b100;
      set_req(2, 4'd8, 32'h0000_0008);
      #1;
      check("t3_park_gnt", gnt, 3'b100);
      step();
      req = 3'b111;
      set_req(0, 4'd1, 32'hA000_0001);
      set_req(1, 4'd2, 32'hA000_0002);
      set_req(2, 4'd10, 32'hA000_000A);
      for (int i = 0; i < 6; i++) begin
         #1;
         check("t3_gnt", gnt, 3'b001 << (i % 3));
         check("t3_regwrite", RegWrite, 1);
         if (i > 0) begin
            case ((i - 1) % 3)
               0: check("t3_writereg", WriteReg, 1);
               1: check("t3_writereg", WriteReg, 2);
               default: check("t3_writereg", WriteReg, 10);
            endcase
         end
         step();
      end
      req = '0;
      check("t3_last_regwrite", RegWrite, 1);
      check("t3_last_writedata", WriteData, 32'hA000_000A);
      step();
      check("t3_idle", RegWrite, 0);

      // ---- Test 4: grant order and withdraw ----
      req = 3'b001;
      set_req(0, 4'd4, 32'h0000_0044);
      #1;
      check("t4_ptr0_gnt", gnt, 3'b001);
      step();
      req = 3'b110;
      set_req(1, 4'd11, 32'h0000_00B1);
      set_req(2, 4'd13, 32'h0000_00C2);
      #1;
      check("t4_gnt_1", gnt, 3'b010);
      step();
      req = 3'b100;
      #1;
      check("t4_gnt_2", gnt, 3'b100);
      check("t4_writereg_11", WriteReg, 11);
      step();
      req = '0;
      check("t4_writereg_13", WriteReg, 13);
      check("t4_writedata_c2", WriteData, 32'h0000_00C2);
      req = 3'b011;
      set_req(0, 4'd14, 32'h0000_00E0);
      set_req(1, 4'd12, 32'h0000_00D1);
      #1;
      check("t4_gnt_wd", gnt, 3'b001);
      step();
      req = 3'b000;
      #1;
      check("t4_gnt_none", gnt, 0);
      check("t4_writereg_14", WriteReg, 14);
      step();
      check("t4_no_write", RegWrite, 0);
      step();
      check("t4_rf12", rf[12], 0);
      check("t4_rf14", rf[14], 32'h0000_00E0);
      check("t4_rf11", rf[11], 32'h0000_00B1);

      // ---- Test 5: scoreboard set/clear, same-edge re-reserve ----
      reserve_en   = 1'b1;
      reserve_addr = 4'd5;
      step();
      reserve_en = 1'b0;
      rd_addr1   = 4'd5;
      rd_addr2   = 4'd6;
      req        = 3'b001;
      set_req(0, 4'd5, 32'h0000_0055);
      #1;
      check("t5_haz1_set", hazard1, 1);
      check("t5_haz2_clr", hazard2, 0);
      step();
      req = '0;
      check("t5_regwrite", RegWrite, 1);
      check("t5_haz1_commit", hazard1, 1);
      reserve_en   = 1'b1;
      reserve_addr = 4'd5;
      step();
      reserve_en = 1'b0;
      check("t5_haz1_rereserve", hazard1, 1);
      check("t5_sb_err_ok", sb_err, 0);
      check("t5_rf5", rf[5], 32'h0000_0055);
      req = 3'b001;
      set_req(0, 4'd5, 32'h0000_0056);
      step();
      req = '0;
      check("t5_haz1_commit2", hazard1, 1);
      step();
      check("t5_haz1_cleared", hazard1, 0);
      check("t5_sb_err_ok2", sb_err, 0);

      // ---- Test 6: double reserve sets sticky error ----
      reserve_en   = 1'b1;
      reserve_addr = 4'd7;
      step();
      step();
      reserve_en = 1'b0;
      rd_addr2   = 4'd7;
      #1;
      check("t6_sb_err", sb_err, 1);
      check("t6_haz2", hazard2, 1);
      req = 3'b001;
      set_req(0, 4'd7, 32'h0000_0077);
      step();
      req = '0;
      step();
      check("t6_haz2_cleared", hazard2, 0);
      check("t6_sb_err_sticky", sb_err, 1);
      rst = 1'b1;
      #1;
      check("t6_sb_err_rst", sb_err, 0);
      step();
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
